// File: rtl/odc_pkg.sv
// Shared definitions for the online (signed-digit) to two's-complement converter:
// digit encodings, FSM state type and the digit decode helper.
package odc_pkg;

  localparam logic [1:0] DIG_POS  = 2'b01;
  localparam logic [1:0] DIG_NEG  = 2'b10;
  localparam logic [1:0] DIG_ZERO = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    CONV,
    HOLD
  } odc_state_e;

  // Both 2'b00 and 2'b11 encode a zero digit.
  function automatic logic signed [1:0] digit_decode(input logic [1:0] d);
    case (d)
      DIG_POS: return 2'sd1;
      DIG_NEG: return -2'sd1;
      default: return 2'sd0;
    endcase
  endfunction

endpackage

// File: rtl/odc_otf_step.sv
// One on-the-fly conversion step: folds one signed digit into the Q/QM pair.
// QM always tracks Q minus one LSB, so a -1 digit never needs a borrow chain.
module odc_otf_step
  import odc_pkg::*;
#(
  parameter int W = 12
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  input  logic [1:0]   digit,
  output logic [W-1:0] q_next,
  output logic [W-1:0] qm_next
);

  always_comb begin
    q_next  = q << 1;
    qm_next = (qm << 1) | W'(1);
    case (digit_decode(digit))
      2'sb01: begin
        q_next  = (q << 1) | W'(1);
        qm_next = q << 1;
      end
      2'sb11: begin
        q_next  = (qm << 1) | W'(1);
        qm_next = qm << 1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/online_digit_converter.sv
// MSD-first radix-2 signed-digit to two's-complement converter with delay-digit stripping.
// Define ODC_ZERO_CHECK_EN to flag non-zero delay digits through err.
module online_digit_converter
  import odc_pkg::*;
#(
  parameter int NDIG  = 11,
  parameter int DELTA = 2
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          din_valid,
  input  logic          din_first,
  input  logic [1:0]    din,
  output logic          din_ready,
  output logic [NDIG:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          err
);

  localparam int CMAX = (NDIG > DELTA) ? NDIG : DELTA;
  localparam int CW   = $clog2(CMAX + 1) + 1;

  odc_state_e    state, state_next;
  logic [CW-1:0] count, count_next, count_inc, step_index;
  logic [NDIG:0] q, qm, q_next, qm_next;
  logic [NDIG:0] step_q_in, step_qm_in, step_q, step_qm;
  logic [NDIG:0] dout_next;
  logic          dout_valid_next, err_next;
  logic          accept, do_step, step_from_init;

  assign din_ready = !Reset && (state != HOLD);
  assign accept    = din_valid && din_ready;
  assign count_inc = count + 1'b1;

  // A restart with DELTA==0 converts its digit from the initial Q/QM pair.
  assign step_q_in  = step_from_init ? '0 : q;
  assign step_qm_in = step_from_init ? '1 : qm;

  odc_otf_step #(.W(NDIG + 1)) u_step (
    .q       (step_q_in),
    .qm      (step_qm_in),
    .digit   (din),
    .q_next  (step_q),
    .qm_next (step_qm)
  );

`ifdef ODC_ZERO_CHECK_EN
  logic delay_digit;
  assign delay_digit = accept && (DELTA > 0) && (din_first || (state == SKIP));
`endif

  always_comb begin
    state_next      = state;
    count_next      = count;
    q_next          = q;
    qm_next         = qm;
    dout_next       = dout;
    dout_valid_next = dout_valid;
    err_next        = err;
    do_step         = 1'b0;
    step_from_init  = 1'b0;
    step_index      = count_inc;

    if (accept) begin
      if (din_first) begin
        // A first digit always opens a new word; mid-word it also aborts the old one.
        if (state != IDLE) err_next = 1'b1;
        q_next  = '0;
        qm_next = '1;
        if (DELTA == 0) begin
          do_step        = 1'b1;
          step_from_init = 1'b1;
          step_index     = CW'(1);
        end else if (DELTA == 1) begin
          state_next = CONV;
          count_next = '0;
        end else begin
          state_next = SKIP;
          count_next = CW'(1);
        end
      end else begin
        case (state)
          IDLE: err_next = 1'b1;
          SKIP: begin
            if (count_inc == CW'(DELTA)) begin
              state_next = CONV;
              count_next = '0;
            end else begin
              count_next = count_inc;
            end
          end
          CONV:    do_step = 1'b1;
          default: ;
        endcase
      end
    end

    if (do_step) begin
      q_next     = step_q;
      qm_next    = step_qm;
      count_next = step_index;
      state_next = CONV;
      if (step_index == CW'(NDIG)) begin
        dout_next       = step_q;
        dout_valid_next = 1'b1;
        q_next          = '0;
        qm_next         = '1;
        count_next      = '0;
        state_next      = HOLD;
      end
    end

`ifdef ODC_ZERO_CHECK_EN
    if (delay_digit && (digit_decode(din) != 2'sd0)) err_next = 1'b1;
`endif

    if ((state == HOLD) && dout_valid && dout_ready) begin
      dout_valid_next = 1'b0;
      state_next      = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state      <= IDLE;
      count      <= '0;
      q          <= '0;
      qm         <= '1;
      dout       <= '0;
      dout_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      q          <= q_next;
      qm         <= qm_next;
      dout       <= dout_next;
      dout_valid <= dout_valid_next;
      err        <= err_next;
    end
  end

endmodule

// File: doc/online_digit_converter.md
Name: online_digit_converter

Overview:
- Digit-serial, MSD-first converter from radix-2 signed-digit (online) format to conventional two's-complement fraction.
- Sits downstream of the online multiplier array and turns its z digit stream into a parallel word for non-online logic.
- Uses on-the-fly conversion: Q/QM register pair, no carry-propagate adder.
- Also strips the multiplier's leading online-delay digits.

Parameters:
- NDIG, 11, significant digits per word (result digits d1..dNDIG).
- DELTA, 2, leading online-delay digits discarded before d1 (0 allowed).

Ports:
- clk, input, 1, clock; all logic on rising edge.
- Reset, input, 1, synchronous active-high reset.
- din_valid, input, 1, digit present on din this cycle.
- din_first, input, 1, qualifies din_valid; marks first digit of a word, the first delay digit when DELTA>0.
- din, input, 2, signed digit: 2'b01=+1, 2'b10=-1, 2'b00/2'b11=0.
- din_ready, output, 1, converter accepts a digit this cycle.
- dout, output, NDIG+1, two's-complement result; integer value = sum d_i*2^(NDIG-i), i.e. fraction scaled by 2^NDIG.
- dout_valid, output, 1, dout holds a completed word.
- dout_ready, input, 1, consumer takes dout this cycle.
- err, output, 1, sticky framing/delay-digit error flag; cleared only by Reset.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous, active-high (Reset).
- Reset values: din_ready=0 during Reset, 1 in the first cycle after; dout=0, dout_valid=0, err=0; Q=0, QM=all ones; state=IDLE; digit counter=0.
- Digit acceptance: a digit is accepted when din_valid & din_ready.
- States: IDLE, SKIP, CONV, HOLD.
- IDLE:
  - din_ready=1.
  - Accepted digit with din_first:
    - DELTA>0: go to SKIP, count=1. If DELTA==1, go straight to CONV.
    - DELTA==0: treat as d1, go to CONV, count=1.
  - Accepted digit without din_first: discarded, err set.
- SKIP: digits discarded. After DELTA total delay digits, go to CONV with count=0.
- CONV: on each accepted digit, apply one on-the-fly step to Q and QM:
  - d=+1: Q'=2Q+1, QM'=2Q.
  - d=0: Q'=2Q, QM'=2QM+1.
  - d=-1: Q'=2QM+1, QM'=2QM.
  - Arithmetic is NDIG+1 bits, wrap discarded. |Q|<2^NDIG, so no overflow is possible.
  - After digit NDIG: dout<=Q', dout_valid<=1 next cycle (latency 1 cycle after last digit), Q<=0, QM<=all ones, state -> HOLD.
- HOLD:
  - din_ready=0.
  - On dout_valid & dout_ready: dout_valid<=0 next cycle, state -> IDLE.
  - dout is held stable until accepted.
  - Back-to-back words: din_ready rises the cycle after the handshake. A word therefore takes DELTA+NDIG+1 cycles minimum plus consumer stall.
- din_first mid-word (SKIP or CONV):
  - Current word aborted, err set.
  - The digit is taken as the first digit of a new word: SKIP reinitialised, Q/QM reinitialised.
- din_valid low: state and registers hold; gaps between digits are allowed.
- Reset mid-word or mid-HOLD: all state returns to reset values; any pending dout is lost.

Optional Feature:
- Macro: ODC_ZERO_CHECK_EN.
- Defined: any non-zero digit (01 or 10) accepted in SKIP sets err. Such a digit means the upstream online-delay assumption was violated. Conversion continues unchanged.
- Undefined: delay-digit values are ignored; only framing errors set err.

Decomposition:
- Package odc_pkg holds:
  - Digit encoding constants: DIG_POS=2'b01, DIG_NEG=2'b10, DIG_ZERO=2'b00.
  - State encoding: IDLE, SKIP, CONV, HOLD.
  - Digit-decode function returning +1/0/-1.
- One combinational sub-module, odc_otf_step:
  - Inputs: Q, QM, digit.
  - Outputs: Q', QM' (width NDIG+1).
  - Instantiated once; also reusable by a future bit-parallel converter.

Test Plan:
- NDIG=4, DELTA=2: stream first{00},00,01,00,10,01 -> dout=5'b00111 (+7 = 7/16), dout_valid 1 cycle after last digit, err=0.
- NDIG=4, DELTA=2: delay digits 00,00 then -1,-1,-1,-1 -> dout=5'b10001 (-15); then -1,+1,+1,+1 -> dout=5'b11111 (-1).
- Backpressure: hold dout_ready=0 for 5 cycles after completion -> dout stable, din_ready=0; raise dout_ready -> din_ready=1 next cycle, next word converts correctly.
- din_first asserted at third significant digit -> err=1; the following complete word still converts to its correct value.
- With ODC_ZERO_CHECK_EN, delay digit 01 -> err=1, dout unchanged from correct conversion. Without the macro -> err=0.
- Reset asserted mid-CONV with gapped din_valid -> dout=0, dout_valid=0, err=0; a fresh word afterward converts correctly.
